// File: rtl/vga_fb_arbiter_if.sv
// CPU write channel into the framebuffer arbiter.
//   wr_req  : write request, held by the requester until acknowledged
//   wr_addr : framebuffer address of the write
//   wr_data : pixel value to write
//   wr_ack  : one-cycle pulse, request accepted into the write FIFO
//   wr_full : write FIFO full, requests are not accepted
// master = CPU side, slave = arbiter side.
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_full;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack,
        input  wr_full
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack,
        output wr_full
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares one single-port synchronous RAM between VGA scan-out
// reads and buffered CPU pixel writes. Each active pixel gets a read slot (RD) on
// the rising edge of the half-rate pixel clock; every other cycle is a write slot
// that drains the CPU write FIFO.
//
// Ports:
//   i_clk          system clock, 2x pixel rate
//   i_rst_n        asynchronous reset, active-low
//   i_vga_clk      half-rate pixel clock, a flop output in the i_clk domain
//   i_vga_blank_n  active-video flag
//   i_screen_pos_x current pixel column
//   i_screen_pos_y current pixel row
//   wr_if          CPU write channel (req/addr/data in, ack/full out)
//   o_mem_addr     RAM address
//   o_mem_wdata    RAM write data
//   o_mem_we       RAM write enable
//   i_mem_rdata    RAM read data, valid one cycle after the address
//   o_pixel        registered pixel to the DAC
//
// Display latency: the read address is issued in the cycle after pix_rise and
// o_pixel takes the RAM data two cycles after that, so the pixel on o_pixel
// always trails the sampled screen position by one pixel.
module vga_fb_arbiter #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vga_clk,
    input  logic              i_vga_blank_n,
    input  logic [9:0]        i_screen_pos_x,
    input  logic [9:0]        i_screen_pos_y,
    vga_fb_arbiter_if.slave   wr_if,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_pixel
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    // Y*H_RES + X needs 10 + clog2(H_RES) bits plus one for the carry of the add.
    localparam int unsigned PROD_MIN = 11 + $clog2(H_RES);
    localparam int unsigned PROD_W   = (ADDR_W > PROD_MIN) ? ADDR_W : PROD_MIN;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StCap
    } state_e;

    state_e            r_state;
    logic              r_vga_clk_q;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_wr_full;
    logic              r_wr_ack;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_pixel;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];

    logic              w_pix_rise;
    logic              w_active;
    logic              w_start_rd;
    logic              w_rd_next;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_next;
    logic [PROD_W-1:0] w_disp_full;
    logic [ADDR_W-1:0] w_disp_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_pix_rise   = i_vga_clk & ~r_vga_clk_q;
        w_active     = i_vga_blank_n
                       & (32'(i_screen_pos_x) < H_RES)
                       & (32'(i_screen_pos_y) < V_RES);
        w_start_rd   = w_pix_rise & w_active;
        // The cycle after RD is always CAP, so a new read can only be scheduled
        // from IDLE or CAP.
        w_rd_next    = w_start_rd & (r_state != StRd);
        // Full is judged on the current count: a pop in the same cycle does not
        // make room for a push.
        w_push       = wr_if.wr_req & ~r_wr_full;
        w_pop        = (r_count != '0) & ~w_rd_next;
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_disp_full  = PROD_W'(i_screen_pos_y) * PROD_W'(H_RES) + PROD_W'(i_screen_pos_x);
        w_disp_addr  = w_disp_full[ADDR_W-1:0];
    end

    // FIFO storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_if.wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_if.wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_vga_clk_q <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_full   <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_pixel     <= '0;
        end else begin
            r_vga_clk_q <= i_vga_clk;
            r_wr_ack    <= w_push;
            r_count     <= w_count_next;
            r_wr_full   <= (w_count_next == CNT_W'(FIFO_DEPTH));
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end

            // RAM port: display read slot, else a write slot that drains the FIFO.
            // The address is left untouched in an idle write slot.
            if (w_rd_next) begin
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_disp_addr;
            end else if (w_pop) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_fifo_addr[r_rd_ptr];
                r_mem_wdata <= r_fifo_data[r_rd_ptr];
            end else begin
                r_mem_we <= 1'b0;
            end

            // Blank pixel on a pixel edge outside active video. A capture in the
            // same cycle is assigned later and wins, so the last active pixel is
            // still shown; the next blank edge clears it.
            if (w_pix_rise && !w_active) begin
                r_pixel <= '0;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_start_rd) begin
                        r_state <= StRd;
                    end
                end
                StRd: begin
                    r_state <= StCap;
                end
                StCap: begin
                    r_pixel <= i_mem_rdata;
                    r_state <= w_start_rd ? StRd : StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign wr_if.wr_ack  = r_wr_ack;
    assign wr_if.wr_full = r_wr_full;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_we      = r_mem_we;
    assign o_pixel       = r_pixel;

endmodule
